// File: rtl/sector_stream_packer.sv
// Packs a byte-wide sector stream into 32-bit words: one header word, the data
// packed little-endian, and a trailer word carrying the byte count and a long flag.
module sector_stream_packer #(
  parameter int unsigned MAX_BYTES = 1023
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [7:0]  s_tdata,
  input  logic        s_tlast,
  input  logic [7:0]  s_tid,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] m_tdata,
  output logic [3:0]  m_tkeep,
  output logic        m_tlast,
  output logic [15:0] sector_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_TRAILER
  } state_t;

  state_t      state, state_next;
  logic [1:0]  lane;
  logic [15:0] byte_count;
  logic [31:0] accumulator;

  logic        out_free;
  logic        accept;
  logic        load_hdr;
  logic        load_word;
  logic        load_trl;
  logic [31:0] word_data;
  logic [3:0]  word_keep;
  logic        trl_long;

  assign out_free = !m_tvalid || m_tready;

  // Saturation at 16'hFFFF forces the long flag even if MAX_BYTES is that large.
  assign trl_long = ({16'h0000, byte_count} > MAX_BYTES) || (&byte_count);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    s_tready   = 1'b0;
    accept     = 1'b0;
    load_hdr   = 1'b0;
    load_word  = 1'b0;
    load_trl   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable && s_tvalid && out_free) begin
          load_hdr   = 1'b1;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        // A word-completing byte may only be taken when the output stage can accept it.
        s_tready  = ((lane != 2'd3) && !s_tlast) || out_free;
        accept    = s_tvalid && s_tready;
        load_word = accept && ((lane == 2'd3) || s_tlast);
        if (accept && s_tlast) begin
          state_next = ST_TRAILER;
        end
      end
      ST_TRAILER: begin
        if (out_free) begin
          load_trl   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    word_data = accumulator;
    word_keep = 4'h1;
    unique case (lane)
      2'd0: begin word_data[7:0]   = s_tdata; word_keep = 4'h1; end
      2'd1: begin word_data[15:8]  = s_tdata; word_keep = 4'h3; end
      2'd2: begin word_data[23:16] = s_tdata; word_keep = 4'h7; end
      2'd3: begin word_data[31:24] = s_tdata; word_keep = 4'hF; end
      default: begin word_data = accumulator; word_keep = 4'h1; end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      lane        <= '0;
      byte_count  <= '0;
      accumulator <= '0;
    end else begin
      if (accept) begin
        if (byte_count != 16'hFFFF) begin
          byte_count <= byte_count + 16'd1;
        end
        if (load_word) begin
          lane        <= '0;
          accumulator <= '0;
        end else begin
          lane        <= lane + 2'd1;
          accumulator <= word_data;
        end
      end
      if (load_trl) begin
        byte_count <= '0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_tvalid     <= 1'b0;
      m_tdata      <= '0;
      m_tkeep      <= '0;
      m_tlast      <= 1'b0;
      sector_count <= '0;
    end else if (load_hdr) begin
      m_tvalid <= 1'b1;
      m_tdata  <= {16'hE5D1, 8'h00, s_tid};
      m_tkeep  <= 4'hF;
      m_tlast  <= 1'b0;
    end else if (load_word) begin
      m_tvalid <= 1'b1;
      m_tdata  <= word_data;
      m_tkeep  <= word_keep;
      m_tlast  <= 1'b0;
    end else if (load_trl) begin
      m_tvalid     <= 1'b1;
      m_tdata      <= {trl_long, 15'b0, byte_count};
      m_tkeep      <= 4'hF;
      m_tlast      <= 1'b1;
      sector_count <= sector_count + 16'd1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sector_stream_packer.sv
// Directed bench for sector_stream_packer: expected words are hand-computed constants;
// a second instance with MAX_BYTES=8 shares the stimulus to exercise the long flag.
module tb_sector_stream_packer;

  logic        aclk;
  logic        areset;
  logic        enable;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  s_tdata;
  logic        s_tlast;
  logic [7:0]  s_tid;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic [15:0] sector_count;

  logic        s_tready8;
  logic        m_tvalid8;
  logic [31:0] m_tdata8;
  logic [3:0]  m_tkeep8;
  logic        m_tlast8;
  logic [15:0] sector_count8;

  int unsigned checks;
  int unsigned errors;

  logic [36:0] q[$];
  logic [31:0] q8[$];

  sector_stream_packer #(.MAX_BYTES(1023)) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .s_tid(s_tid),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .sector_count(sector_count)
  );

  sector_stream_packer #(.MAX_BYTES(8)) dut8 (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_tvalid(s_tvalid), .s_tready(s_tready8), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .s_tid(s_tid),
    .m_tvalid(m_tvalid8), .m_tready(m_tready), .m_tdata(m_tdata8),
    .m_tkeep(m_tkeep8), .m_tlast(m_tlast8), .sector_count(sector_count8)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Outputs are stable between posedge+1 and the next posedge, so a handshake
  // seen at the negedge is the one taken at the following posedge.
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) q.push_back({m_tdata, m_tkeep, m_tlast});
    if (!areset && m_tvalid8 && m_tready && m_tlast8) q8.push_back(m_tdata8);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [36:0] obs;
    if (q.size() > 0) obs = q.pop_front();
    else obs = 'x;
    chk(tag, 64'(obs), 64'({d, k, l}));
  endtask

  task automatic chk_trl8(input string tag, input logic [31:0] d);
    logic [31:0] obs;
    if (q8.size() > 0) obs = q8.pop_front();
    else obs = 'x;
    chk(tag, 64'(obs), 64'(d));
  endtask

  // Drives bytes (i+1) for i < stop_after; tlast on byte n-1. Entered and left at posedge+1.
  task automatic send(input logic [7:0] tid, input int unsigned n, input int unsigned stop_after);
    for (int unsigned i = 0; i < stop_after; i++) begin
      int unsigned waited;
      logic        got;
      s_tvalid = 1'b1;
      s_tdata  = 8'(i + 1);
      s_tlast  = (i == n - 1);
      s_tid    = tid;
      waited   = 0;
      got      = 1'b0;
      while (!got && waited < 100) begin
        @(negedge aclk);
        if (s_tready) got = 1'b1;
        else waited++;
      end
      if (!got) begin
        chk("byte_accept_timeout", 64'(got), 64'(1));
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    int unsigned bad;
    checks   = 0;
    errors   = 0;
    areset   = 1'b1;
    enable   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tid    = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tdata", 64'(m_tdata), 64'(0));
    chk("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_sector_count", 64'(sector_count), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    @(posedge aclk);
    #1;

    // 4-byte sector
    send(8'h12, 4, 4);
    idle_cycles(6);
    chk_word("s4_hdr", 32'hE5D10012, 4'hF, 1'b0);
    chk_word("s4_w0", 32'h04030201, 4'hF, 1'b0);
    chk_word("s4_trl", 32'h00000004, 4'hF, 1'b1);
    chk("s4_sector_count", 64'(sector_count), 64'(1));
    chk("s4_q_empty", 64'(q.size()), 64'(0));

    // 6-byte sector: final partial word keep 3
    send(8'h07, 6, 6);
    idle_cycles(6);
    chk_word("s6_hdr", 32'hE5D10007, 4'hF, 1'b0);
    chk_word("s6_w0", 32'h04030201, 4'hF, 1'b0);
    chk_word("s6_w1", 32'h00000605, 4'h3, 1'b0);
    chk_word("s6_trl", 32'h00000006, 4'hF, 1'b1);
    chk("s6_sector_count", 64'(sector_count), 64'(2));

    // 12-byte sector with the header held for 10 cycles
    m_tready = 1'b0;
    fork
      send(8'h0C, 12, 12);
      begin
        int unsigned w;
        w = 0;
        while (!m_tvalid && w < 50) begin
          @(negedge aclk);
          w++;
        end
        repeat (5) @(negedge aclk);
        chk("bp_s_tready_lane3", 64'(s_tready), 64'(0));
        chk("bp_hdr_held", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'hE5D1000C}));
        repeat (4) @(negedge aclk);
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
    join
    idle_cycles(6);
    chk_word("bp_hdr", 32'hE5D1000C, 4'hF, 1'b0);
    chk_word("bp_w0", 32'h04030201, 4'hF, 1'b0);
    chk_word("bp_w1", 32'h08070605, 4'hF, 1'b0);
    chk_word("bp_w2", 32'h0C0B0A09, 4'hF, 1'b0);
    chk_word("bp_trl", 32'h0000000C, 4'hF, 1'b1);
    chk("bp_sector_count", 64'(sector_count), 64'(3));

    // 10-byte sector: long only on the MAX_BYTES=8 instance
    q8.delete();
    send(8'h0A, 10, 10);
    idle_cycles(6);
    chk_word("s10_hdr", 32'hE5D1000A, 4'hF, 1'b0);
    chk_word("s10_w0", 32'h04030201, 4'hF, 1'b0);
    chk_word("s10_w1", 32'h08070605, 4'hF, 1'b0);
    chk_word("s10_w2", 32'h00000A09, 4'h3, 1'b0);
    chk_word("s10_trl", 32'h0000000A, 4'hF, 1'b1);
    chk_trl8("s10_trl_max8", 32'h8000000A);

    // 1023-byte sector: exactly MAX_BYTES is not long
    send(8'h3F, 1023, 1023);
    idle_cycles(6);
    chk("s1023_word_count", 64'(q.size()), 64'(258));
    chk_word("s1023_hdr", 32'hE5D1003F, 4'hF, 1'b0);
    for (int unsigned i = 0; i < 254; i++) void'(q.pop_front());
    chk_word("s1023_w254", 32'hFCFBFAF9, 4'hF, 1'b0);
    chk_word("s1023_w255", 32'h00FFFEFD, 4'h7, 1'b0);
    chk_word("s1023_trl", 32'h000003FF, 4'hF, 1'b1);
    chk_trl8("s1023_trl_max8", 32'h800003FF);
    chk("s1023_sector_count", 64'(sector_count), 64'(5));

    // reset after 5 bytes of an 8-byte sector
    send(8'h21, 8, 5);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_mid_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_mid_sector_count", 64'(sector_count), 64'(0));
    chk("rst_mid_s_tready", 64'(s_tready), 64'(0));
    q.delete();
    @(posedge aclk);
    #1;
    send(8'h33, 4, 4);
    idle_cycles(6);
    chk_word("post_rst_hdr", 32'hE5D10033, 4'hF, 1'b0);
    chk_word("post_rst_w0", 32'h04030201, 4'hF, 1'b0);
    chk_word("post_rst_trl", 32'h00000004, 4'hF, 1'b1);
    chk("post_rst_sector_count", 64'(sector_count), 64'(1));

    // enable low holds off the sector start
    enable   = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'h01;
    s_tlast  = 1'b0;
    s_tid    = 8'h44;
    bad = 0;
    repeat (20) begin
      @(negedge aclk);
      if (s_tready !== 1'b0 || m_tvalid !== 1'b0) bad++;
    end
    chk("en_low_stall", 64'(bad), 64'(0));
    @(posedge aclk);
    #1;
    enable = 1'b1;
    @(negedge aclk);
    chk("en_hdr_latency", 64'(m_tvalid), 64'(0));
    @(posedge aclk);
    #1;
    enable = 1'b0;
    chk("en_hdr_loaded", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'hE5D10044}));
    send(8'h44, 4, 4);
    idle_cycles(6);
    chk_word("en_hdr", 32'hE5D10044, 4'hF, 1'b0);
    chk_word("en_w0", 32'h04030201, 4'hF, 1'b0);
    chk_word("en_trl", 32'h00000004, 4'hF, 1'b1);
    chk("en_sector_count", 64'(sector_count), 64'(2));

    // next sector waits in IDLE until enable returns
    s_tvalid = 1'b1;
    s_tdata  = 8'h01;
    s_tid    = 8'h55;
    bad = 0;
    repeat (8) begin
      @(negedge aclk);
      if (s_tready !== 1'b0 || m_tvalid !== 1'b0) bad++;
    end
    chk("en_wait_idle", 64'(bad), 64'(0));
    @(posedge aclk);
    #1;
    enable = 1'b1;
    send(8'h55, 4, 4);
    idle_cycles(6);
    chk_word("en2_hdr", 32'hE5D10055, 4'hF, 1'b0);
    chk_word("en2_w0", 32'h04030201, 4'hF, 1'b0);
    chk_word("en2_trl", 32'h00000004, 4'hF, 1'b1);
    chk("en2_sector_count", 64'(sector_count), 64'(3));
    chk("final_q_empty", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
